// File: rtl/rr_sel_pkg.sv
// Shared definitions for the round-robin bus selector: mode encodings and
// one-hot helper functions used by the top level and the arbiter.
package rr_sel_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Widest channel vector the helpers accept; callers zero-extend into it.
  localparam int MAX_CH = 32;

  // True when exactly one bit of vec is set.
  function automatic logic onehot_chk(input logic [MAX_CH-1:0] vec);
    return (vec != '0) && ((vec & (vec - MAX_CH'(1))) == '0);
  endfunction

  // Index of the set bit in a one-hot vector (0 when vec is all zero).
  function automatic int oh2idx(input logic [MAX_CH-1:0] vec);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: owns the priority pointer and performs the
// wrap-around search starting one past the last granted channel.
module rr_arbiter
  import rr_sel_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic           en,
  input  logic           upd,
  output logic [NCH-1:0] grant
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CW-1:0]  ptr_reg;
  logic [NCH-1:0] grant_next;
  logic           found;
  logic [CW-1:0]  idx;

  // Priority search from (ptr+1) mod NCH upward; first requester wins.
  always_comb begin
    grant_next = '0;
    found      = 1'b0;
    idx        = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = CW'((int'(ptr_reg) + k) % NCH);
      if (!found && req[idx]) begin
        grant_next[idx] = 1'b1;
        found           = 1'b1;
      end
    end
  end

  assign grant = en ? grant_next : '0;

  // Pointer follows the granted channel; reset value gives channel 0 first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= CW'(NCH - 1);
    end else if (upd && (|grant)) begin
      ptr_reg <= CW'(oh2idx(MAX_CH'(grant)));
    end
  end

endmodule

// File: rtl/rr_bus_selector.sv
// Registered NCH-channel bus selector with valid/ready handshakes.
// FIXED mode forwards the one-hot selected channel, RR mode arbitrates
// round-robin; a single output register stage feeds one consumer.
module rr_bus_selector
  import rr_sel_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  localparam int CW    = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [NCH-1:0]     sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]     in_valid,
  output logic [NCH-1:0]     in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [CW-1:0]      out_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);

  logic [WIDTH-1:0] out_data_reg;
  logic [CW-1:0]    out_ch_reg;
  logic             out_valid_reg;
  logic             sel_err_reg;

  logic             load;
  logic             mode_rr;
  logic             sel_ok;
  logic             sel_err_next;
  logic [NCH-1:0]   fixed_grant;
  logic [NCH-1:0]   rr_grant;
  logic [NCH-1:0]   grant;
  logic [WIDTH-1:0] data_next;
  logic [CW-1:0]    ch_next;
  logic [WIDTH-1:0] masked [NCH];

  // The output register can take a new word when empty or being drained.
  assign load    = !out_valid_reg || out_ready;
  assign mode_rr = (mode == MODE_RR);
  assign sel_ok  = onehot_chk(MAX_CH'(sel));

  assign fixed_grant = (load && !mode_rr && sel_ok) ? (sel & in_valid) : '0;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (in_valid),
    .en    (load && mode_rr),
    .upd   (load && mode_rr),
    .grant (rr_grant)
  );

  assign grant = mode_rr ? rr_grant : fixed_grant;

  // Handshake ready is suppressed while reset is asserted.
  assign in_ready = rst_n ? grant : '0;

  // A malformed select only counts as an error when something was waiting.
  assign sel_err_next = !mode_rr && load && (|in_valid) && !sel_ok;

  // Zero every non-granted channel so the data mux reduces to an OR.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_mask
    assign masked[gi] = grant[gi] ? in_data[gi*WIDTH +: WIDTH] : '0;
  end

  // OR-reduce the masked channel words into the selected word.
  always_comb begin
    data_next = '0;
    for (int i = 0; i < NCH; i++) begin
      data_next = data_next | masked[i];
    end
  end

  assign ch_next = CW'(oh2idx(MAX_CH'(grant)));

  // Output register: load on grant, drop valid on an empty load, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      out_valid_reg <= 1'b0;
      sel_err_reg   <= 1'b0;
    end else begin
      sel_err_reg <= sel_err_next;
      if (load) begin
        if (|grant) begin
          out_data_reg  <= data_next;
          out_ch_reg    <= ch_next;
          out_valid_reg <= 1'b1;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;
  assign out_valid = out_valid_reg;
  assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_rr_bus_selector.sv
// Directed testbench for rr_bus_selector with a reference arbitration model
// and a scoreboard queue of expected output words.
module tb_rr_bus_selector;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int CW    = 2;

  logic               clk;
  logic               rst_n;
  logic               mode;
  logic [NCH-1:0]     sel;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]     in_valid;
  logic [NCH-1:0]     in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [CW-1:0]      out_ch;
  logic               out_valid;
  logic               out_ready;
  logic               sel_err;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               ch;
  } word_t;

  word_t sbq[$];

  int checks;
  int errors;
  int in_cnt;
  int out_cnt;

  // Reference model state
  int   m_ptr;
  logic m_valid;
  logic m_err;

  rr_bus_selector #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected grant given the current inputs and model state.
  function automatic logic [NCH-1:0] model_grant(input logic ld);
    logic [NCH-1:0] g;
    int c;
    g = '0;
    if (ld) begin
      if (mode == 1'b0) begin
        if ($countones(sel) == 1) g = sel & in_valid;
      end else begin
        for (int k = 1; k <= NCH; k++) begin
          c = (m_ptr + k) % NCH;
          if (g == '0 && in_valid[c]) g[c] = 1'b1;
        end
      end
    end
    return g;
  endfunction

  // One clock cycle: inputs were driven at the falling edge; check, update model.
  task automatic cycle(input string tag);
    logic [NCH-1:0] g;
    logic ld;
    int idx;
    word_t w;
    #1;
    ld = !m_valid || out_ready;
    g  = model_grant(ld);
    chk({tag, "/in_ready"}, 32'(in_ready), 32'(g));
    chk({tag, "/out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, "/sel_err"}, 32'(sel_err), 32'(m_err));
    if (m_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s/scoreboard: observed=word expected=empty", tag);
      end else begin
        chk({tag, "/out_data"}, 32'(out_data), 32'(sbq[0].d));
        chk({tag, "/out_ch"}, 32'(out_ch), 32'(sbq[0].ch));
        if (out_ready) begin
          w = sbq.pop_front();
          out_cnt++;
          $display("[%0t] %s: out ch=%0d data=%02h", $time, tag, w.ch, w.d);
        end
      end
    end
    if (g != '0) begin
      idx = 0;
      for (int i = 0; i < NCH; i++) if (g[i]) idx = i;
      w.d  = in_data[idx*WIDTH +: WIDTH];
      w.ch = idx;
      sbq.push_back(w);
      in_cnt++;
      if (mode == 1'b1) m_ptr = idx;
    end
    m_err = (mode == 1'b0) && ld && (|in_valid) && ($countones(sel) != 1);
    if (ld) m_valid = (g != '0);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_ptr   = NCH - 1;
    m_valid = 1'b0;
    m_err   = 1'b0;
    sbq.delete();
    in_cnt  = 0;
    out_cnt = 0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel       = '0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    chk("reset/out_valid", 32'(out_valid), 32'(0));
    chk("reset/out_data", 32'(out_data), 32'(0));
    chk("reset/out_ch", 32'(out_ch), 32'(0));
    chk("reset/sel_err", 32'(sel_err), 32'(0));
    chk("reset/in_ready", 32'(in_ready), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: RR, all channels valid -> 0,1,2,3,0
    mode     = 1'b1;
    in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) cycle("t1_rr");

    // 2: FIXED select of ch2, then malformed select
    mode    = 1'b0;
    sel     = 4'b0100;
    in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    cycle("t2_fix");
    sel = 4'b0110;
    cycle("t2_bad");
    sel = 4'b0100;
    cycle("t2_err");
    in_valid = 4'b0000;
    cycle("t2_clr");
    cycle("t2_idle");

    // 3: RR stall with 3C held, then release
    mode     = 1'b1;
    in_valid = 4'b1111;
    in_data  = {8'h44, 8'h55, 8'h3C, 8'h11};
    cycle("t3_load");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle("t3_stall");
    out_ready = 1'b1;
    cycle("t3_rel");
    cycle("t3_next");

    // 5: async reset while a word is held
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst/out_valid", 32'(out_valid), 32'(0));
    chk("t5_rst/out_data", 32'(out_data), 32'(0));
    chk("t5_rst/out_ch", 32'(out_ch), 32'(0));
    chk("t5_rst/in_ready", 32'(in_ready), 32'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // 4: wrap-around from ptr=3 to ch0, then ch1 alone, then wrap to ch3
    in_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    in_valid = 4'b1001;
    cycle("t4_wrap");
    in_valid = 4'b0010;
    cycle("t4_ch1");
    in_valid = 4'b1001;
    cycle("t4_ch3");

    // 6: RR -> FIXED -> RR mid-stream, pointer preserved
    in_valid = 4'b1111;
    cycle("t6_rr");
    mode = 1'b0;
    sel  = 4'b0001;
    cycle("t6_fix");
    cycle("t6_fix");
    mode = 1'b1;
    for (int i = 0; i < 4; i++) cycle("t6_rr2");
    in_valid = 4'b0000;
    cycle("t6_drain");
    cycle("t6_drain");
    chk("t6/count", 32'(out_cnt), 32'(in_cnt));
    chk("t6/sb_empty", 32'(sbq.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
